// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-first bypass and a per-register busy scoreboard
// used by decode to detect RAW/WAW hazards. Register 0 reads zero and is never busy.
module regfile_scoreboard #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned NUM_READ   = 2,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
  localparam int unsigned CNT_WIDTH  = $clog2(NUM_REGS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] READ_Addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] READ_Data,
  output logic [NUM_READ-1:0]            READ_Busy,
  input  logic                           WRITE_En,
  input  logic [ADDR_WIDTH-1:0]          WRITE_Addr,
  input  logic [DATA_WIDTH-1:0]          WRITE_Data,
  input  logic                           Issue_Valid,
  input  logic [ADDR_WIDTH-1:0]          Issue_Addr,
  output logic                           Issue_Ready,
  input  logic                           Flush,
  output logic [CNT_WIDTH-1:0]           Busy_Count
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d, busy_eff;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  wr_hit;
  logic                  reserve;

  assign wr_hit = WRITE_En && (WRITE_Addr != '0);

  // Busy bits with any same-cycle writeback already cleared.
  always_comb begin
    busy_eff = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_eff[r] = busy_q[r] & ~(WRITE_En && (WRITE_Addr == ADDR_WIDTH'(r)));
    end
  end

  assign Issue_Ready = !reset && !Flush && ((Issue_Addr == '0) || !busy_eff[Issue_Addr]);
  assign reserve     = Issue_Valid && Issue_Ready;

  // Reservation beats a same-cycle writeback to the same register (WAW chaining).
  always_comb begin
    busy_d = '0;
    cnt_d  = '0;
    if (!Flush) begin
      busy_d = busy_eff;
      if (reserve && (Issue_Addr != '0)) begin
        busy_d[Issue_Addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d = cnt_d + CNT_WIDTH'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (wr_hit) begin
        mem_q[WRITE_Addr] <= WRITE_Data;
      end
    end
  end

  assign Busy_Count = cnt_q;

  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    ra        = '0;
    READ_Data = '0;
    READ_Busy = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra = READ_Addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (wr_hit && (WRITE_Addr == ra)) begin
        READ_Data[i*DATA_WIDTH +: DATA_WIDTH] = WRITE_Data;
      end else begin
        READ_Data[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[ra];
      end
      READ_Busy[i] = busy_q[ra] & ~(WRITE_En && (WRITE_Addr == ra));
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default 2-port/32-bit instance plus a
// 4-port/64-bit instance to exercise the packed port slicing.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Instance A: defaults
  logic        a_reset, a_we, a_iv, a_irdy, a_flush;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic [4:0]  a_waddr, a_iaddr;
  logic [31:0] a_wdata;
  logic [5:0]  a_cnt;

  regfile_scoreboard u_dut_a (
    .clk         (clk),
    .reset       (a_reset),
    .READ_Addr   (a_raddr),
    .READ_Data   (a_rdata),
    .READ_Busy   (a_rbusy),
    .WRITE_En    (a_we),
    .WRITE_Addr  (a_waddr),
    .WRITE_Data  (a_wdata),
    .Issue_Valid (a_iv),
    .Issue_Addr  (a_iaddr),
    .Issue_Ready (a_irdy),
    .Flush       (a_flush),
    .Busy_Count  (a_cnt)
  );

  // Instance B: four read ports, 64-bit data
  logic         b_reset, b_we, b_iv, b_irdy, b_flush;
  logic [19:0]  b_raddr;
  logic [255:0] b_rdata;
  logic [3:0]   b_rbusy;
  logic [4:0]   b_waddr, b_iaddr;
  logic [63:0]  b_wdata;
  logic [5:0]   b_cnt;

  regfile_scoreboard #(
    .DATA_WIDTH (64),
    .NUM_REGS   (32),
    .NUM_READ   (4)
  ) u_dut_b (
    .clk         (clk),
    .reset       (b_reset),
    .READ_Addr   (b_raddr),
    .READ_Data   (b_rdata),
    .READ_Busy   (b_rbusy),
    .WRITE_En    (b_we),
    .WRITE_Addr  (b_waddr),
    .WRITE_Data  (b_wdata),
    .Issue_Valid (b_iv),
    .Issue_Addr  (b_iaddr),
    .Issue_Ready (b_irdy),
    .Flush       (b_flush),
    .Busy_Count  (b_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] a_rd(input int p);
    return a_rdata[p*32 +: 32];
  endfunction

  function automatic logic [63:0] b_rd(input int p);
    return b_rdata[p*64 +: 64];
  endfunction

  logic [63:0] b_vals [4];

  initial begin
    b_vals[0] = 64'h0123_4567_89AB_CDEF;
    b_vals[1] = 64'hFEDC_BA98_7654_3210;
    b_vals[2] = 64'hA5A5_A5A5_5A5A_5A5A;
    b_vals[3] = 64'h8000_0000_0000_0001;

    a_reset = 1'b1; a_we = 1'b0; a_iv = 1'b0; a_flush = 1'b0;
    a_raddr = '0; a_waddr = '0; a_iaddr = '0; a_wdata = '0;
    b_reset = 1'b1; b_we = 1'b0; b_iv = 1'b0; b_flush = 1'b0;
    b_raddr = '0; b_waddr = '0; b_iaddr = '0; b_wdata = '0;
    tick();
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Reset state across all registers on both ports
    for (int r = 0; r < 32; r++) begin
      a_raddr = {r[4:0], r[4:0]};
      #1;
      check_eq($sformatf("rst_data0_x%0d", r), a_rd(0), 0);
      check_eq($sformatf("rst_data1_x%0d", r), a_rd(1), 0);
      check_eq($sformatf("rst_busy_x%0d", r), a_rbusy, 0);
    end
    check_eq("rst_cnt", a_cnt, 0);

    // Write x5 with same-cycle read bypass
    a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'hDEADBEEF;
    a_raddr = {5'd0, 5'd5};
    #1 check_eq("x5_bypass", a_rd(0), 32'hDEADBEEF);
    tick();
    a_we = 1'b0;
    #1 check_eq("x5_stored", a_rd(0), 32'hDEADBEEF);
    tick();
    check_eq("x5_stored2", a_rd(0), 32'hDEADBEEF);

    // Writes to x0 are ignored, including the bypass path
    a_we = 1'b1; a_waddr = 5'd0; a_wdata = 32'h1234;
    #1 check_eq("x0_wr_same", a_rd(1), 0);
    tick();
    a_we = 1'b0;
    #1 check_eq("x0_wr_after", a_rd(1), 0);

    // Issue x7, hold a second request, then writeback clears combinationally
    a_raddr = {5'd0, 5'd7};
    a_iv = 1'b1; a_iaddr = 5'd7;
    #1 check_eq("x7_rdy_free", a_irdy, 1);
    check_eq("x7_busy_pre", a_rbusy[0], 0);
    tick();
    check_eq("x7_busy", a_rbusy[0], 1);
    check_eq("x7_cnt1", a_cnt, 1);
    check_eq("x7_rdy_held", a_irdy, 0);
    tick();
    check_eq("x7_cnt_held", a_cnt, 1);
    a_iv = 1'b0;
    a_we = 1'b1; a_waddr = 5'd7; a_wdata = 32'h55;
    #1 check_eq("x7_wb_busy", a_rbusy[0], 0);
    check_eq("x7_wb_rdy", a_irdy, 1);
    check_eq("x7_wb_byp", a_rd(0), 32'h55);
    tick();
    a_we = 1'b0;
    #1 check_eq("x7_data", a_rd(0), 32'h55);
    check_eq("x7_cnt0", a_cnt, 0);
    check_eq("x7_busy_clr", a_rbusy[0], 0);

    // WAW chaining on x9
    a_iv = 1'b1; a_iaddr = 5'd9;
    tick();
    check_eq("x9_cnt1", a_cnt, 1);
    a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'hA;
    a_raddr = {5'd0, 5'd9};
    #1 check_eq("x9_waw_rdy", a_irdy, 1);
    tick();
    a_iv = 1'b0; a_we = 1'b0;
    #1 check_eq("x9_data", a_rd(0), 32'hA);
    check_eq("x9_still_busy", a_rbusy[0], 1);
    check_eq("x9_cnt_same", a_cnt, 1);

    // Fill x1..x3, reserve them, then flush with a competing issue
    for (int k = 1; k <= 3; k++) begin
      a_we = 1'b1; a_waddr = k[4:0]; a_wdata = 32'h11 * k;
      tick();
    end
    a_we = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      a_iv = 1'b1; a_iaddr = k[4:0];
      tick();
    end
    a_iv = 1'b0;
    #1 check_eq("pre_flush_cnt", a_cnt, 4);
    a_flush = 1'b1; a_iv = 1'b1; a_iaddr = 5'd4;
    #1 check_eq("flush_rdy", a_irdy, 0);
    tick();
    a_flush = 1'b0; a_iv = 1'b0;
    a_raddr = {5'd2, 5'd1};
    #1 check_eq("flush_cnt", a_cnt, 0);
    check_eq("flush_busy12", a_rbusy, 0);
    check_eq("flush_x1", a_rd(0), 32'h11);
    check_eq("flush_x2", a_rd(1), 32'h22);
    a_raddr = {5'd4, 5'd3};
    #1 check_eq("flush_busy34", a_rbusy, 0);
    check_eq("flush_x3", a_rd(0), 32'h33);
    a_raddr = {5'd9, 5'd9};
    #1 check_eq("flush_x9_busy", a_rbusy, 0);
    check_eq("flush_x9_data", a_rd(1), 32'hA);

    // Reset overrides same-cycle write and issue
    a_we = 1'b1; a_waddr = 5'd10; a_wdata = 32'h99;
    tick();
    a_we = 1'b0;
    a_raddr = {5'd11, 5'd10};
    #1 check_eq("x10_pre", a_rd(0), 32'h99);
    a_reset = 1'b1;
    a_we = 1'b1; a_waddr = 5'd10; a_wdata = 32'hFFFF;
    a_iv = 1'b1; a_iaddr = 5'd11;
    #1 check_eq("rst_rdy", a_irdy, 0);
    tick();
    a_reset = 1'b0; a_we = 1'b0; a_iv = 1'b0;
    #1 check_eq("rst_x10", a_rd(0), 0);
    check_eq("rst_x11_busy", a_rbusy[1], 0);
    check_eq("rst_cnt2", a_cnt, 0);
    a_raddr = {5'd5, 5'd7};
    #1 check_eq("rst_x7", a_rd(0), 0);
    check_eq("rst_x5", a_rd(1), 0);

    // Instance B: packed 4-port, 64-bit slicing
    for (int k = 0; k < 4; k++) begin
      b_we = 1'b1; b_waddr = 5'(k + 4); b_wdata = b_vals[k];
      tick();
    end
    b_we = 1'b0;
    b_raddr = {5'd7, 5'd6, 5'd5, 5'd4};
    #1;
    for (int p = 0; p < 4; p++) begin
      check_eq($sformatf("b_data_p%0d", p), b_rd(p), b_vals[p]);
    end
    b_iv = 1'b1; b_iaddr = 5'd6;
    tick();
    b_iv = 1'b0;
    #1 check_eq("b_busy_x6", b_rbusy, 4'b0100);
    check_eq("b_cnt1", b_cnt, 1);
    b_we = 1'b1; b_waddr = 5'd6; b_wdata = 64'hFFFF_0000_FFFF_0000;
    #1 check_eq("b_byp_x6", b_rd(2), 64'hFFFF_0000_FFFF_0000);
    check_eq("b_wb_busy", b_rbusy, 4'b0000);
    check_eq("b_other_p3", b_rd(3), b_vals[3]);
    tick();
    b_we = 1'b0;
    #1 check_eq("b_cnt0", b_cnt, 0);
    b_reset = 1'b1;
    b_we = 1'b1; b_waddr = 5'd5; b_wdata = 64'h1;
    b_iv = 1'b1; b_iaddr = 5'd7;
    tick();
    b_reset = 1'b0; b_we = 1'b0; b_iv = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      check_eq($sformatf("b_rst_p%0d", p), b_rd(p), 0);
    end
    check_eq("b_rst_busy", b_rbusy, 0);
    check_eq("b_rst_cnt", b_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
